button_controller: RTL

//   Turns one raw, bouncy, active-low pushbutton into clean, single-cycle UI events.
//   The pin comes from an SB_IO pad with internal pull-up enabled; the button shorts it to ground.

---
 rtl/button_pkg.sv | 20 ++
 rtl/button_debounce.sv | 79 +++++++
 rtl/button_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton controller: FSM states, default
// 12 MHz timing constants and a small constant-width helper.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  // Defaults for a 12 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 120_000;     // 10 ms
  localparam int DEF_LONG_CYCLES     = 12_000_000;  // 1 s
  localparam int DEF_REPEAT_CYCLES   = 2_400_000;   // 200 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter for an active-low button.
// level_o is the debounced level (1 = down); rise_o/fall_o pulse for one
// cycle in the same cycle the debounced level changes.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din_n_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_n_q, level_n_d;   // debounced level, pad polarity
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          mismatch;
  logic          flip;

  // Bring the asynchronous pad level into the clock domain; resets to released.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours (sync2_q gets the old sync1_q).
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreements; accept the new level on the last one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    mismatch  = (sync2_q != level_n_q);
    flip      = mismatch && (cnt_q == CNT_LAST);
    cnt_d     = '0;
    level_n_d = level_n_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (flip) begin
      level_n_d = sync2_q;
      rise_d    = ~sync2_q;
      fall_d    = sync2_q;
    end else if (mismatch) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      level_n_q <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_n_q <= level_n_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign level_o = ~level_n_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/button_controller.sv
// Pushbutton event generator: debounced level plus single-cycle press,
// release, long-press and auto-repeat pulses, all registered.
module button_controller
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  input  logic repeat_en_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int HW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

  logic          level, rise, fall;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_done, repeat_done;
  logic          pressed_d, press_d, release_d, long_press_d, repeat_d;
  logic          pressed_q, press_q, release_q, long_press_q, repeat_q;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .din_n_i (btn_n_i),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // Terminal counts: the cycle whose edge will emit long_press / repeat.
  assign long_done   = (hold_cnt_q == LONG_LAST);
  assign repeat_done = (hold_cnt_q == REPEAT_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a debounced release always takes priority over a timer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (rise) state_d = ST_DOWN;
      ST_DOWN: begin
        if (fall)           state_d = ST_IDLE;
        else if (long_done) state_d = ST_HELD;
      end
      ST_HELD: if (fall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and hold-counter logic; counter clears on every state change and wrap.
  always_comb begin
    pressed_d    = level;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_press_d = 1'b0;
    repeat_d     = 1'b0;
    hold_cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: press_d = rise;
      ST_DOWN: begin
        if (fall)           release_d    = 1'b1;
        else if (long_done) long_press_d = 1'b1;
        else                hold_cnt_d   = hold_cnt_q + HW'(1);
      end
      ST_HELD: begin
        if (fall)             release_d  = 1'b1;
        else if (repeat_done) repeat_d   = repeat_en_i;
        else                  hold_cnt_d = hold_cnt_q + HW'(1);
      end
      default: ;
    endcase
  end

  // Registered outputs and hold counter; reset drops everything without a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      pressed_q    <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      pressed_q    <= pressed_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
      repeat_q     <= repeat_d;
    end
  end

  assign pressed_o    = pressed_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_press_q;
  assign repeat_o     = repeat_q;

endmodule
